// File: rtl/std_cache_mshr_file.sv
// Miss-status holding register file: tracks several outstanding line misses,
// hands them to the miss handler in allocation order, and blocks secondary misses.
module std_cache_mshr_file #(
  parameter int unsigned NR_ENTRIES  = 4,
  parameter int unsigned NR_PORTS    = 3,
  parameter int unsigned ADDR_WIDTH  = 56,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned LINE_OFFSET = 4,
  localparam int unsigned IDW  = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1,
  localparam int unsigned IXW  = $clog2(NR_ENTRIES),
  localparam int unsigned BEW  = DATA_WIDTH / 8,
  localparam int unsigned TAGW = ADDR_WIDTH - LINE_OFFSET
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           alloc_req_i,
  output logic                           alloc_gnt_o,
  input  logic [IDW-1:0]                 alloc_id_i,
  input  logic [ADDR_WIDTH-1:0]          alloc_addr_i,
  input  logic                           alloc_we_i,
  input  logic [DATA_WIDTH-1:0]          alloc_wdata_i,
  input  logic [BEW-1:0]                 alloc_be_i,
  output logic [IXW-1:0]                 alloc_idx_o,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0] lookup_addr_i,
  output logic [NR_PORTS-1:0]            lookup_match_o,
  output logic                           issue_valid_o,
  input  logic                           issue_ready_i,
  output logic [IXW-1:0]                 issue_idx_o,
  output logic [IDW-1:0]                 issue_id_o,
  output logic [ADDR_WIDTH-1:0]          issue_addr_o,
  output logic                           issue_we_o,
  output logic [DATA_WIDTH-1:0]          issue_wdata_o,
  output logic [BEW-1:0]                 issue_be_o,
  input  logic                           retire_valid_i,
  input  logic [IXW-1:0]                 retire_idx_i,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [IXW:0]                   count_o
);

  typedef enum logic [1:0] {FREE, PENDING, INFLIGHT} state_e;

  state_e                state_q [NR_ENTRIES];
  state_e                state_d [NR_ENTRIES];
  logic [IDW-1:0]        id_q    [NR_ENTRIES];
  logic [IDW-1:0]        id_d    [NR_ENTRIES];
  logic [ADDR_WIDTH-1:0] addr_q  [NR_ENTRIES];
  logic [ADDR_WIDTH-1:0] addr_d  [NR_ENTRIES];
  logic                  we_q    [NR_ENTRIES];
  logic                  we_d    [NR_ENTRIES];
  logic [DATA_WIDTH-1:0] data_q  [NR_ENTRIES];
  logic [DATA_WIDTH-1:0] data_d  [NR_ENTRIES];
  logic [BEW-1:0]        be_q    [NR_ENTRIES];
  logic [BEW-1:0]        be_d    [NR_ENTRIES];

  logic [IXW-1:0] fifo_q [NR_ENTRIES];
  logic [IXW-1:0] fifo_d [NR_ENTRIES];
  logic [IXW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IXW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IXW:0]   fifo_cnt_q, fifo_cnt_d;

  logic [TAGW-1:0] probe_tag [NR_PORTS];
  logic            alloc_match;
  logic            free_found;
  logic [IXW-1:0]  free_idx;
  logic [IXW:0]    busy_cnt;
  logic [IXW-1:0]  head_idx;
  logic            pop;
  logic            unused_lookup_lsbs;

  always_comb begin
    unused_lookup_lsbs = 1'b0;
    for (int p = 0; p < NR_PORTS; p++) begin
      probe_tag[p] = lookup_addr_i[p*ADDR_WIDTH+LINE_OFFSET +: TAGW];
      unused_lookup_lsbs = unused_lookup_lsbs ^ (^lookup_addr_i[p*ADDR_WIDTH +: LINE_OFFSET]);
    end
  end

  // Line-granular matching against every busy (PENDING or INFLIGHT) entry.
  always_comb begin
    alloc_match    = 1'b0;
    lookup_match_o = '0;
    for (int e = 0; e < NR_ENTRIES; e++) begin
      if (state_q[e] != FREE) begin
        if (addr_q[e][ADDR_WIDTH-1:LINE_OFFSET] == alloc_addr_i[ADDR_WIDTH-1:LINE_OFFSET])
          alloc_match = 1'b1;
        for (int p = 0; p < NR_PORTS; p++) begin
          if (addr_q[e][ADDR_WIDTH-1:LINE_OFFSET] == probe_tag[p])
            lookup_match_o[p] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    busy_cnt   = '0;
    for (int e = NR_ENTRIES - 1; e >= 0; e--) begin
      if (state_q[e] == FREE) begin
        free_found = 1'b1;
        free_idx   = IXW'(e);
      end else begin
        busy_cnt = busy_cnt + (IXW+1)'(1);
      end
    end
  end

  assign count_o     = busy_cnt;
  assign full_o      = !free_found;
  assign empty_o     = (busy_cnt == '0);
  assign alloc_gnt_o = rst_ni & alloc_req_i & !full_o & !alloc_match;
  assign alloc_idx_o = free_idx;

  assign head_idx      = fifo_q[rd_ptr_q];
  assign issue_valid_o = (fifo_cnt_q != '0);
  assign pop           = issue_valid_o & issue_ready_i;

  // Fields are forced to zero while nothing is offered so an idle FIFO shows no stale entry.
  always_comb begin
    issue_idx_o   = '0;
    issue_id_o    = '0;
    issue_addr_o  = '0;
    issue_we_o    = 1'b0;
    issue_wdata_o = '0;
    issue_be_o    = '0;
    if (issue_valid_o) begin
      issue_idx_o   = head_idx;
      issue_id_o    = id_q[head_idx];
      issue_addr_o  = addr_q[head_idx];
      issue_we_o    = we_q[head_idx];
      issue_wdata_o = data_q[head_idx];
      issue_be_o    = be_q[head_idx];
    end
  end

  // Pop, retire and alloc always touch distinct entries, so their updates never collide.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    we_d       = we_q;
    data_d     = data_q;
    be_d       = be_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;

    if (pop) begin
      state_d[head_idx] = INFLIGHT;
      rd_ptr_d          = rd_ptr_q + IXW'(1);
    end

    if (retire_valid_i && state_q[retire_idx_i] == INFLIGHT)
      state_d[retire_idx_i] = FREE;

    if (alloc_gnt_o) begin
      state_d[free_idx] = PENDING;
      id_d[free_idx]    = alloc_id_i;
      addr_d[free_idx]  = alloc_addr_i;
      we_d[free_idx]    = alloc_we_i;
      data_d[free_idx]  = alloc_wdata_i;
      be_d[free_idx]    = alloc_be_i;
      fifo_d[wr_ptr_q]  = free_idx;
      wr_ptr_d          = wr_ptr_q + IXW'(1);
    end

    fifo_cnt_d = fifo_cnt_q + (IXW+1)'(alloc_gnt_o) - (IXW+1)'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < NR_ENTRIES; e++) begin
        state_q[e] <= FREE;
        id_q[e]    <= '0;
        addr_q[e]  <= '0;
        we_q[e]    <= 1'b0;
        data_q[e]  <= '0;
        be_q[e]    <= '0;
        fifo_q[e]  <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      data_q     <= data_d;
      be_q       <= be_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Only an entry already handed to the miss handler may be retired.
  retire_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    retire_valid_i |-> state_q[retire_idx_i] == INFLIGHT);

endmodule

// File: tb/tb_std_cache_mshr_file.sv
// Directed bench for std_cache_mshr_file: expected issue records go to a scoreboard
// queue, and a monitor compares each one against the miss-handler handshake.
module tb_std_cache_mshr_file;

  localparam int AW = 56;
  localparam int DW = 64;

  typedef struct {
    logic [1:0]    idx;
    logic [1:0]    id;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [7:0]    be;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          alloc_req_i = 1'b0;
  logic          alloc_gnt_o;
  logic [1:0]    alloc_id_i = '0;
  logic [AW-1:0] alloc_addr_i = '0;
  logic          alloc_we_i = 1'b0;
  logic [DW-1:0] alloc_wdata_i = '0;
  logic [7:0]    alloc_be_i = '0;
  logic [1:0]    alloc_idx_o;
  logic [3*AW-1:0] lookup_addr_i = '0;
  logic [2:0]    lookup_match_o;
  logic          issue_valid_o;
  logic          issue_ready_i = 1'b0;
  logic [1:0]    issue_idx_o;
  logic [1:0]    issue_id_o;
  logic [AW-1:0] issue_addr_o;
  logic          issue_we_o;
  logic [DW-1:0] issue_wdata_o;
  logic [7:0]    issue_be_o;
  logic          retire_valid_i = 1'b0;
  logic [1:0]    retire_idx_i = '0;
  logic          full_o;
  logic          empty_o;
  logic [2:0]    count_o;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  exp_t popped;

  std_cache_mshr_file dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_id_i(alloc_id_i),
    .alloc_addr_i(alloc_addr_i), .alloc_we_i(alloc_we_i), .alloc_wdata_i(alloc_wdata_i),
    .alloc_be_i(alloc_be_i), .alloc_idx_o(alloc_idx_o),
    .lookup_addr_i(lookup_addr_i), .lookup_match_o(lookup_match_o),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_idx_o(issue_idx_o), .issue_id_o(issue_id_o), .issue_addr_o(issue_addr_o),
    .issue_we_o(issue_we_o), .issue_wdata_o(issue_wdata_o), .issue_be_o(issue_be_o),
    .retire_valid_i(retire_valid_i), .retire_idx_i(retire_idx_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] mkData(input logic [AW-1:0] a);
    return {a[31:0] ^ 32'hDEADBEEF, a[31:0]};
  endfunction

  function automatic logic [1:0] mkId(input logic [AW-1:0] a);
    return 2'(a[15:12] % 3);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [AW-1:0] addr, input logic we,
                               input logic [7:0] be, input logic rdy, input logic rv,
                               input logic [1:0] ridx);
    alloc_req_i    = req;
    alloc_addr_i   = addr;
    alloc_we_i     = we;
    alloc_be_i     = be;
    alloc_id_i     = mkId(addr);
    alloc_wdata_i  = mkData(addr);
    issue_ready_i  = rdy;
    retire_valid_i = rv;
    retire_idx_i   = ridx;
  endtask

  // Drive one cycle's inputs and stop at the falling edge; expGnt<0 skips the grant check.
  task automatic doCycle(input logic req, input logic [AW-1:0] addr, input logic we,
                         input logic [7:0] be, input logic rdy, input logic rv,
                         input logic [1:0] ridx, input int expGnt, input logic [1:0] expIdx);
    exp_t e;
    applyStimulus(req, addr, we, be, rdy, rv, ridx);
    @(negedge clk_i);
    if (expGnt >= 0) begin
      checkOutput("alloc_gnt", 64'(alloc_gnt_o), 64'(expGnt));
      if (expGnt == 1) begin
        checkOutput("alloc_idx", 64'(alloc_idx_o), 64'(expIdx));
        e.idx = expIdx; e.id = mkId(addr); e.addr = addr; e.we = we;
        e.wdata = mkData(addr); e.be = be;
        expQ.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic rdy, input logic rv, input logic [1:0] ridx);
    doCycle(1'b0, '0, 1'b0, 8'h00, rdy, rv, ridx, -1, 2'd0);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_issue_valid", 64'(issue_valid_o), 64'd0);
    checkOutput("rst_full", 64'(full_o), 64'd0);
    checkOutput("rst_empty", 64'(empty_o), 64'd1);
    checkOutput("rst_count", 64'(count_o), 64'd0);
    checkOutput("rst_match", 64'(lookup_match_o), 64'd0);
    checkOutput("rst_issue_addr", 64'(issue_addr_o), 64'd0);
    checkOutput("rst_gnt", 64'(alloc_gnt_o), 64'd0);
  endtask

  // Scoreboard monitor: every issue handshake must match the oldest expected allocation.
  always @(negedge clk_i) begin
    if (rst_ni && issue_valid_o && issue_ready_i) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL issue_unexpected actual idx=%0d required=no issue", issue_idx_o);
      end else begin
        popped = expQ.pop_front();
        checkOutput("issue_idx", 64'(issue_idx_o), 64'(popped.idx));
        checkOutput("issue_id", 64'(issue_id_o), 64'(popped.id));
        checkOutput("issue_addr", 64'(issue_addr_o), 64'(popped.addr));
        checkOutput("issue_we", 64'(issue_we_o), 64'(popped.we));
        checkOutput("issue_wdata", issue_wdata_o, popped.wdata);
        checkOutput("issue_be", 64'(issue_be_o), 64'(popped.be));
      end
    end
  end

  initial begin
    // Reset state, including a held request that must not be granted.
    alloc_req_i  = 1'b1;
    alloc_addr_i = 56'h1000;
    #12;
    checkResetValues();
    tick();
    rst_ni = 1'b1;

    // Single store miss and its issue/retire.
    doCycle(1'b1, 56'h1000, 1'b1, 8'h0F, 1'b0, 1'b0, 2'd0, 1, 2'd0);
    tick();
    idle(1'b0, 1'b0, 2'd0);
    checkOutput("t1_issue_valid", 64'(issue_valid_o), 64'd1);
    checkOutput("t1_issue_addr", 64'(issue_addr_o), 64'h1000);
    checkOutput("t1_count", 64'(count_o), 64'd1);
    checkOutput("t1_empty", 64'(empty_o), 64'd0);
    tick();
    idle(1'b1, 1'b0, 2'd0);
    tick();
    idle(1'b0, 1'b1, 2'd0);
    checkOutput("t1_inflight_count", 64'(count_o), 64'd1);
    tick();

    // Fill all entries, refuse a fifth, free entry 2 and reuse it a cycle later.
    doCycle(1'b1, 56'h1000, 1'b0, 8'hFF, 1'b0, 1'b0, 2'd0, 1, 2'd0);
    checkOutput("t2_empty_before", 64'(empty_o), 64'd1);
    tick();
    doCycle(1'b1, 56'h2000, 1'b1, 8'h03, 1'b0, 1'b0, 2'd0, 1, 2'd1); tick();
    doCycle(1'b1, 56'h3000, 1'b1, 8'hF0, 1'b0, 1'b0, 2'd0, 1, 2'd2); tick();
    doCycle(1'b1, 56'h4000, 1'b0, 8'h81, 1'b0, 1'b0, 2'd0, 1, 2'd3); tick();
    doCycle(1'b1, 56'h5000, 1'b1, 8'h3C, 1'b0, 1'b0, 2'd0, 0, 2'd0);
    checkOutput("t2_full", 64'(full_o), 64'd1);
    checkOutput("t2_count", 64'(count_o), 64'd4);
    tick();
    for (int i = 0; i < 4; i++) begin
      idle(1'b1, 1'b0, 2'd0);
      tick();
    end
    doCycle(1'b1, 56'h5000, 1'b1, 8'h3C, 1'b0, 1'b1, 2'd2, 0, 2'd0);
    tick();
    doCycle(1'b1, 56'h5000, 1'b1, 8'h3C, 1'b0, 1'b0, 2'd0, 1, 2'd2);
    checkOutput("t2_full_after_retire", 64'(full_o), 64'd0);
    checkOutput("t2_count_after_retire", 64'(count_o), 64'd3);
    tick();
    idle(1'b1, 1'b0, 2'd0); tick();
    idle(1'b0, 1'b1, 2'd0); tick();
    idle(1'b0, 1'b1, 2'd1); tick();
    idle(1'b0, 1'b1, 2'd3); tick();
    idle(1'b0, 1'b1, 2'd2); tick();

    // Secondary miss to a busy line is refused; probes match at line granularity.
    doCycle(1'b1, 56'h1040, 1'b0, 8'hFF, 1'b0, 1'b0, 2'd0, 1, 2'd0);
    tick();
    lookup_addr_i = {56'h1040, 56'h1050, 56'h1044};
    doCycle(1'b1, 56'h1048, 1'b0, 8'hFF, 1'b0, 1'b0, 2'd0, 0, 2'd0);
    checkOutput("t3_lookup", 64'(lookup_match_o), 64'b101);
    tick();
    idle(1'b1, 1'b0, 2'd0); tick();
    idle(1'b0, 1'b1, 2'd0); tick();
    idle(1'b0, 1'b0, 2'd0);
    checkOutput("t3_lookup_freed", 64'(lookup_match_o), 64'b000);
    tick();

    // Issue follows allocation order across a reused index and wrapped pointers.
    doCycle(1'b1, 56'h1000, 1'b1, 8'h01, 1'b0, 1'b0, 2'd0, 1, 2'd0); tick();
    doCycle(1'b1, 56'h2000, 1'b1, 8'h02, 1'b0, 1'b0, 2'd0, 1, 2'd1); tick();
    doCycle(1'b1, 56'h3000, 1'b1, 8'h04, 1'b0, 1'b0, 2'd0, 1, 2'd2); tick();
    idle(1'b1, 1'b0, 2'd0); tick();
    idle(1'b0, 1'b1, 2'd0); tick();
    doCycle(1'b1, 56'h7000, 1'b0, 8'h08, 1'b0, 1'b0, 2'd0, 1, 2'd0); tick();
    idle(1'b1, 1'b0, 2'd0);
    checkOutput("t4_first_issue_idx", 64'(issue_idx_o), 64'd1);
    tick();
    idle(1'b1, 1'b0, 2'd0); tick();
    idle(1'b1, 1'b0, 2'd0); tick();

    // Alloc, issue pop and retire in the same cycle leave the count unchanged.
    idle(1'b0, 1'b1, 2'd1); tick();
    idle(1'b0, 1'b1, 2'd2); tick();
    doCycle(1'b1, 56'h8000, 1'b1, 8'h11, 1'b0, 1'b0, 2'd0, 1, 2'd1); tick();
    doCycle(1'b1, 56'h9000, 1'b1, 8'h22, 1'b1, 1'b1, 2'd0, 1, 2'd2);
    checkOutput("t5_count_before", 64'(count_o), 64'd2);
    tick();
    lookup_addr_i = {56'h9000, 56'h8000, 56'h7000};
    idle(1'b0, 1'b0, 2'd0);
    checkOutput("t5_count_after", 64'(count_o), 64'd2);
    checkOutput("t5_lookup", 64'(lookup_match_o), 64'b110);
    checkOutput("t5_head_idx", 64'(issue_idx_o), 64'd2);
    tick();
    doCycle(1'b1, 56'hA000, 1'b0, 8'h44, 1'b0, 1'b0, 2'd0, 1, 2'd0);
    tick();

    // Asynchronous reset with three busy entries discards everything immediately.
    lookup_addr_i = {56'h9000, 56'h8000, 56'hA000};
    applyStimulus(1'b1, 56'hC000, 1'b0, 8'hFF, 1'b0, 1'b0, 2'd0);
    #1;
    checkOutput("t6_count_pre", 64'(count_o), 64'd3);
    rst_ni = 1'b0;
    #1;
    checkResetValues();
    expQ.delete();
    tick();
    rst_ni = 1'b1;
    doCycle(1'b1, 56'hB000, 1'b1, 8'h55, 1'b0, 1'b0, 2'd0, 1, 2'd0);
    tick();

    for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
      idle(1'b1, 1'b0, 2'd0);
      tick();
    end
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
